// File: rtl/multi_delay_timer.sv
// Multi-channel EN/FIN millisecond delay timer, one-shot or periodic per channel.
// Optional pause input enabled by defining MULTI_DELAY_TIMER_PAUSE_EN.
module multi_delay_timer #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 12,
    parameter int TICK_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       delay_en,
    input  logic [NUM_CH-1:0]       delay_mode,
    input  logic [NUM_CH*CNT_W-1:0] delay_val,
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
    input  logic [NUM_CH-1:0]       delay_pause,
`endif
    output logic [NUM_CH-1:0]       delay_fin,
    output logic [NUM_CH-1:0]       delay_busy
);

    localparam int SUB_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICK_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t             state, state_n;
        logic [SUB_W-1:0]   sub, sub_n;
        logic [CNT_W-1:0]   ms, ms_n;
        logic [CNT_W-1:0]   val, val_n;
        logic [CNT_W-1:0]   ms_inc;
        logic               mode, mode_n;
        logic               strobe, strobe_n;
        logic               paused;

`ifdef MULTI_DELAY_TIMER_PAUSE_EN
        assign paused = delay_pause[c];
`else
        assign paused = 1'b0;
`endif
        // ms only advances while ms+1 < val, so this increment cannot wrap.
        assign ms_inc = ms + CNT_ONE;

        always_comb begin
            // NOTE: every next-state value gets a default first so no path infers a latch.
            state_n  = state;
            sub_n    = sub;
            ms_n     = ms;
            val_n    = val;
            mode_n   = mode;
            strobe_n = 1'b0;
            case (state)
                ST_IDLE: begin
                    sub_n = '0;
                    ms_n  = '0;
                    if (delay_en[c]) begin
                        val_n   = delay_val[c*CNT_W +: CNT_W];
                        mode_n  = delay_mode[c];
                        state_n = (delay_val[c*CNT_W +: CNT_W] == '0) ? ST_DONE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!delay_en[c]) begin
                        state_n = ST_IDLE;
                        sub_n   = '0;
                        ms_n    = '0;
                    end else if (!paused) begin
                        if (sub == SUB_LAST) begin
                            sub_n = '0;
                            if (ms_inc == val) begin
                                ms_n = '0;
                                if (mode) strobe_n = 1'b1;
                                else      state_n  = ST_DONE;
                            end else begin
                                ms_n = ms_inc;
                            end
                        end else begin
                            sub_n = sub + SUB_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!delay_en[c]) state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    sub_n   = '0;
                    ms_n    = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= ST_IDLE;
                sub    <= '0;
                ms     <= '0;
                val    <= '0;
                mode   <= 1'b0;
                strobe <= 1'b0;
            end else begin
                // NOTE: non-blocking updates so all registers advance together on the edge.
                state  <= state_n;
                sub    <= sub_n;
                ms     <= ms_n;
                val    <= val_n;
                mode   <= mode_n;
                strobe <= strobe_n;
            end
        end

        assign delay_fin[c]  = delay_en[c] & ((state == ST_DONE) | strobe);
        assign delay_busy[c] = (state == ST_HOLD);
    end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Directed self-checking bench for multi_delay_timer (NUM_CH=4, CNT_W=4, TICK_CYCLES=4).
// Define MULTI_DELAY_TIMER_PAUSE_EN for both files to exercise the pause input.
module tb_multi_delay_timer;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
    localparam int TICK   = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH-1:0]       en = '0;
    logic [NUM_CH-1:0]       mode = '0;
    logic [NUM_CH*CNT_W-1:0] vals = '0;
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
    logic [NUM_CH-1:0]       pause = '0;
`endif
    logic [NUM_CH-1:0]       fin;
    logic [NUM_CH-1:0]       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_delay_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TICK_CYCLES(TICK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .delay_en   (en),
        .delay_mode (mode),
        .delay_val  (vals),
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
        .delay_pause(pause),
`endif
        .delay_fin  (fin),
        .delay_busy (busy)
    );

    // Advance n rising edges and settle 2 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_val(input int c, input logic [CNT_W-1:0] v);
        vals[c*CNT_W +: CNT_W] = v;
    endtask

    // Returns the number of cycles after e0 until FIN is seen, or -1 when the bound expires.
    task automatic cycles_to_fin(input int c, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            step(1);
            if (fin[c] === 1'b1) begin
                n = k - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        #3;
        n_checks++;
        if (fin !== '0 || busy !== '0) begin
            n_fail++; $display("FAIL reset_outputs: fin=%b busy=%b want 0000/0000", fin, busy);
        end
        step(1);
        rst_n = 1'b1;
        set_val(0, 2); mode[0] = 1'b0; en[0] = 1'b1;
        step(1);
        n_checks++;
        if (busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_busy: busy0=%b want 1", busy[0]);
        end
        step(3);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fin[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: fin0=%b busy0=%b want 0/0", fin[0], busy[0]);
        end
        step(1);
        rst_n = 1'b1;
        cycles_to_fin(0, 40, n);
        n_checks++;
        if (n !== 8) begin
            n_fail++; $display("FAIL reset_restart_latency: got %0d want 8", n);
        end
        en[0] = 1'b0;
        step(2);
    endtask

    task automatic test_one_shot();
        int n;
        set_val(0, 3); mode[0] = 1'b0; en[0] = 1'b1;
        cycles_to_fin(0, 60, n);
        n_checks++;
        if (n !== 12) begin
            n_fail++; $display("FAIL oneshot_latency: got %0d want 12", n);
        end
        n_checks++;
        if (busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_done_busy: busy0=%b want 0", busy[0]);
        end
        set_val(0, 9);
        step(3);
        n_checks++;
        if (fin[0] !== 1'b1) begin
            n_fail++; $display("FAIL oneshot_level: fin0=%b want 1", fin[0]);
        end
        en[0] = 1'b0;
        #1;
        n_checks++;
        if (fin[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_drop: fin0=%b busy0=%b want 0/0", fin[0], busy[0]);
        end
        step(1);
        set_val(0, 1); en[0] = 1'b1;
        cycles_to_fin(0, 20, n);
        n_checks++;
        if (n !== 4) begin
            n_fail++; $display("FAIL oneshot_restart_latency: got %0d want 4", n);
        end
        en[0] = 1'b0;
        step(2);
    endtask

    task automatic test_periodic();
        logic exp_fin;
        set_val(1, 2); mode[1] = 1'b1; en[1] = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            step(1);
            if (k - 1 == 3) set_val(1, 5);
            exp_fin = (k - 1 == 8) || (k - 1 == 16) || (k - 1 == 24);
            n_checks++;
            if (fin[1] !== exp_fin) begin
                n_fail++; $display("FAIL periodic_fin t=%0d: got %b want %b", k - 1, fin[1], exp_fin);
            end
            n_checks++;
            if (busy[1] !== 1'b1) begin
                n_fail++; $display("FAIL periodic_busy t=%0d: got %b want 1", k - 1, busy[1]);
            end
        end
        en[1] = 1'b0; mode[1] = 1'b0;
        step(2);
    endtask

    task automatic test_boundaries();
        int n;
        set_val(2, 0); en[2] = 1'b1;
        step(1);
        n_checks++;
        if (fin[2] !== 1'b1 || busy[2] !== 1'b0) begin
            n_fail++; $display("FAIL zero_val_e0: fin2=%b busy2=%b want 1/0", fin[2], busy[2]);
        end
        step(2);
        n_checks++;
        if (fin[2] !== 1'b1 || busy[2] !== 1'b0) begin
            n_fail++; $display("FAIL zero_val_hold: fin2=%b busy2=%b want 1/0", fin[2], busy[2]);
        end
        en[2] = 1'b0;
        #1;
        n_checks++;
        if (fin[2] !== 1'b0) begin
            n_fail++; $display("FAIL zero_val_drop: fin2=%b want 0", fin[2]);
        end
        step(1);

        set_val(3, 15); en[3] = 1'b1;
        cycles_to_fin(3, 100, n);
        n_checks++;
        if (n !== 60) begin
            n_fail++; $display("FAIL max_val_latency: got %0d want 60", n);
        end
        en[3] = 1'b0;
        step(2);

        en[3] = 1'b1;
        step(60);
        n_checks++;
        if (busy[3] !== 1'b1 || fin[3] !== 1'b0) begin
            n_fail++; $display("FAIL abort_pre: busy3=%b fin3=%b want 1/0", busy[3], fin[3]);
        end
        en[3] = 1'b0;
        step(1);
        n_checks++;
        if (busy[3] !== 1'b0) begin
            n_fail++; $display("FAIL abort_terminal_busy: busy3=%b want 0", busy[3]);
        end
        en[3] = 1'b1;
        #1;
        n_checks++;
        if (fin[3] !== 1'b0) begin
            n_fail++; $display("FAIL abort_terminal_fin: fin3=%b want 0", fin[3]);
        end
        step(1);
        n_checks++;
        if (busy[3] !== 1'b1) begin
            n_fail++; $display("FAIL abort_restart_busy: busy3=%b want 1", busy[3]);
        end
        en[3] = 1'b0;
        step(2);
    endtask

    task automatic test_concurrency();
        int first [NUM_CH];
        for (int c = 0; c < NUM_CH; c++) begin
            first[c] = -1;
            set_val(c, CNT_W'(c + 1));
        end
        mode = '0;
        for (int k = 0; k < 30; k++) begin
            if (k < NUM_CH) en[k] = 1'b1;
            step(1);
            for (int c = 0; c < NUM_CH; c++)
                if (fin[c] === 1'b1 && first[c] < 0) first[c] = k + 1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            n_checks++;
            if (first[c] !== 5 * c + 5) begin
                n_fail++; $display("FAIL concurrent_ch%0d: got edge %0d want %0d", c, first[c], 5 * c + 5);
            end
        end
        en = '0;
        step(2);
    endtask

`ifdef MULTI_DELAY_TIMER_PAUSE_EN
    task automatic test_pause();
        int first;
        first = -1;
        set_val(0, 2); mode[0] = 1'b0; en[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k - 1 >= 3 && k - 1 <= 7) begin
                n_checks++;
                if (busy[0] !== 1'b1 || fin[0] !== 1'b0) begin
                    n_fail++; $display("FAIL pause_hold t=%0d: busy0=%b fin0=%b want 1/0", k - 1, busy[0], fin[0]);
                end
            end
            if (fin[0] === 1'b1 && first < 0) first = k - 1;
            if (k - 1 == 2) pause[0] = 1'b1;
            if (k - 1 == 7) pause[0] = 1'b0;
        end
        n_checks++;
        if (first !== 13) begin
            n_fail++; $display("FAIL pause_latency: got %0d want 13", first);
        end
        en[0] = 1'b0;
        step(2);

        en[0] = 1'b1;
        step(3);
        pause[0] = 1'b1;
        step(2);
        en[0] = 1'b0;
        step(1);
        n_checks++;
        if (busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL pause_abort_busy: busy0=%b want 0", busy[0]);
        end
        en[0] = 1'b1;
        #1;
        n_checks++;
        if (fin[0] !== 1'b0) begin
            n_fail++; $display("FAIL pause_abort_fin: fin0=%b want 0", fin[0]);
        end
        en[0] = 1'b0;
        pause[0] = 1'b0;
        step(2);
    endtask
`endif

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_boundaries();
        test_concurrency();
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
        test_pause();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/multi_delay_timer.md
# multi_delay_timer

Parametrised multi-channel millisecond delay timer for the PmodOLED control path and other sequencers that wait out power-up, reset and refresh intervals. Each of `NUM_CH` independent channels runs an EN/FIN handshake timer counting `DELAY_VAL` ticks of `TICK_CYCLES` clocks, in one-shot (level) or periodic (strobe) mode. Sits beside the OLED controller FSMs so one instance replaces several single-channel delay blocks.

## Interface
- `NUM_CH`, 4, number of independent channels (1..16)
- `CNT_W`, 12, width of each channel's delay value in ticks
- `TICK_CYCLES`, 100000, CLK cycles per tick (1 ms at 100 MHz); must be ≥ 2
- `CLK`  in  1  system clock, all logic on rising edge
- `RST_N`  in  1  reset; one clock; reset is asynchronous and active-low
- `DELAY_EN`  in  NUM_CH  per-channel start/hold request
- `DELAY_MODE`  in  NUM_CH  0 = one-shot, 1 = periodic; sampled at start
- `DELAY_VAL`  in  NUM_CH*CNT_W  channel c delay in ticks at bits [c*CNT_W +: CNT_W]; sampled at start
- `DELAY_FIN`  out  NUM_CH  completion (one-shot: level; periodic: 1-cycle strobe)
- `DELAY_BUSY`  out  NUM_CH  1 while channel is in HOLD

## Operation
- Per-channel FSM: IDLE, HOLD, DONE. Per-channel registers: prescaler `sub` ($clog2(TICK_CYCLES) bits), tick count `ms` (CNT_W), latched `val`, latched `mode`, `strobe`.
- IDLE: `sub`=`ms`=0. If EN=1: latch VAL/MODE; if VAL=0 → DONE, else → HOLD.
- HOLD: if EN=0 → IDLE (abort, counters cleared). Else `sub` increments; when `sub`=TICK_CYCLES-1, `sub`←0 and: if `ms`+1=`val` → terminal, else `ms`++.
- Terminal, one-shot: → DONE, counters cleared. Terminal, periodic: stay HOLD, `ms`←0, `strobe`←1 for one cycle.
- DONE: hold until EN=0, then → IDLE. VAL/MODE changes ignored.
- DELAY_FIN[c] = EN[c] & ((state=DONE) | strobe). DELAY_BUSY[c] = (state=HOLD). Both combinational from registers and EN.
- VAL=0 in either mode: DONE, FIN level while EN high.
- Channels fully independent; no shared prescaler, so timing has no cross-channel jitter.
- Unused/illegal state encoding → IDLE next edge.

## Timing
- Reset (RST_N low, async): all channels IDLE, counters/strobe 0; DELAY_FIN=0, DELAY_BUSY=0 immediately and until first edge after release.
- Let e0 = edge sampling EN=1 in IDLE. VAL=D≥1: DONE entered at edge e0+D·TICK_CYCLES; FIN high from that edge. D=0: DONE at e0, FIN high after e0.
- Periodic: strobe high in cycle after edges e0+k·D·TICK_CYCLES, k=1,2,…; period exactly D·TICK_CYCLES, no dead cycle.
- EN drop: FIN falls combinationally same cycle; state IDLE at next edge. Re-raise of EN in IDLE restarts with fresh sample; minimum one IDLE cycle between runs.
- EN low on the terminal edge: abort wins, → IDLE, no FIN.
- `ms` never wraps: terminal compare fires before overflow; D=2^CNT_W-1 legal.
- Reset mid-HOLD: channel aborts instantly, no FIN.

## Configuration
- `MULTI_DELAY_TIMER_PAUSE_EN`: when defined, adds input port `DELAY_PAUSE` (NUM_CH). In HOLD with PAUSE=1 and EN=1, `sub`/`ms` freeze, BUSY stays 1, no terminal/strobe; EN=0 still aborts. PAUSE ignored in IDLE/DONE. Latency extends by exactly the number of paused HOLD cycles.
- Undefined: no `DELAY_PAUSE` port; HOLD always counts.

## Test plan
(TICK_CYCLES=4, CNT_W=4, NUM_CH=4 in sim.)
- Reset: assert RST_N=0 mid-HOLD on ch0, EN held → FIN=0, BUSY=0 asynchronously; after release ch0 restarts, FIN at e0+D·4.
- One-shot: ch0 VAL=3, EN rises, held → FIN rises exactly 12 cycles after e0, stays high; EN low → FIN low same cycle, BUSY 0, IDLE next edge.
- Periodic: ch1 VAL=2, MODE=1 → 1-cycle FIN strobes at cycles 8, 16, 24 after e0; BUSY constant 1; VAL changed to 5 mid-run → period stays 8.
- Boundaries: ch2 VAL=0 → FIN one cycle after e0, no BUSY; ch3 VAL=15 → FIN at 60 cycles, no wrap; EN dropped on cycle 59 → no FIN.
- Concurrency: all four channels started on different cycles with VAL 1,2,3,4 → each FIN at its own e0+4·D, independent.
- With `MULTI_DELAY_TIMER_PAUSE_EN`: ch0 VAL=2, PAUSE high 5 cycles mid-HOLD → FIN at e0+13; pause with EN low → abort, no FIN.
